// File: rtl/gray_cnt_pkg.sv
// Shared Gray-counter helpers: width limit, direction codes,
// and width-generic bin2gray / gray2bin conversions.
package gray_cnt_pkg;

  localparam int MAX_W = 32;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] r;
    r[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--)
      r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

endpackage

// File: rtl/gray_bit_index.sv
// Priority encoder: one-hot diff -> bit index (lowest set bit wins).
// Ports: diff (WIDTH) in, idx (IDXW) out; purely combinational.
module gray_bit_index #(
  parameter int WIDTH = 4,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] diff,
  output logic [IDXW-1:0]  idx
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (diff[i]) idx = IDXW'(i);
  end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down loadable Gray counter with registered gray/bin, step
// pulse, toggled-bit index and boundary pulse (edge_hit).
// Ports: clk, rst(async hi), en, up, load, load_val -> gray, bin,
//   stepped, toggle_idx, edge_hit.
// Build option: GRAY_CNT_SATURATE_EN blocks wrapping steps.
module gray_counter_param
  import gray_cnt_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = 0,
  localparam int         IDXW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             stepped,
  output logic [IDXW-1:0]  toggle_idx,
  output logic             edge_hit
);

  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_G =
    WIDTH'(bin2gray(MAX_W'(RST_VAL)));

  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [IDXW-1:0]  idx_nxt;
  logic             step;
  logic             hit;
  logic             wrap;

  assign wrap = (up == DIR_UP) ? (&bin) : ~(|bin);

  always_comb begin
    cnt_nxt = bin;
    step    = 1'b0;
    hit     = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
`ifdef GRAY_CNT_SATURATE_EN
      hit  = wrap;
      step = ~wrap;
`else
      hit  = wrap;
      step = 1'b1;
`endif
      if (step)
        cnt_nxt = (up == DIR_UP) ? bin + WIDTH'(1)
                                 : bin - WIDTH'(1);
    end
    gray_nxt = WIDTH'(bin2gray(MAX_W'(cnt_nxt)));
  end

  // Old vs. new gray differ in exactly one bit on a step.
  gray_bit_index #(.WIDTH(WIDTH)) u_idx (
    .diff (gray ^ gray_nxt),
    .idx  (idx_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin        <= RST_B;
      gray       <= RST_G;
      stepped    <= 1'b0;
      edge_hit   <= 1'b0;
      toggle_idx <= '0;
    end else begin
      bin      <= cnt_nxt;
      gray     <= gray_nxt;
      stepped  <= step;
      edge_hit <= hit;
      if (step) toggle_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param (WIDTH=4 directed,
// WIDTH=7 random one-bit-change property).
module tb_gray_counter_param;

`ifdef GRAY_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       s;
    logic       e;
    logic [1:0] t;
    string      name;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       en = 0, up = 1, load = 0;
  logic [3:0] load_val = 0;
  logic [3:0] gray, bin;
  logic       stepped, edge_hit;
  logic [1:0] toggle_idx;

  logic       rst7 = 1, en7 = 0, up7 = 0;
  logic [6:0] gray7, bin7, prev7;
  logic       stepped7, edge7;
  logic [2:0] tidx7;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .gray(gray), .bin(bin),
    .stepped(stepped), .toggle_idx(toggle_idx),
    .edge_hit(edge_hit)
  );

  gray_counter_param #(.WIDTH(7), .RST_VAL(0)) dut7 (
    .clk(clk), .rst(rst7), .en(en7), .up(up7), .load(1'b0),
    .load_val(7'd0), .gray(gray7), .bin(bin7),
    .stepped(stepped7), .toggle_idx(tidx7),
    .edge_hit(edge7)
  );

  task automatic cmp(input exp_t e);
    checks++;
    if ({bin, gray, stepped, edge_hit, toggle_idx} !==
        {e.b, e.g, e.s, e.e, e.t}) begin
      errors++;
      $display("FAIL %s: got bin=%b gray=%b st=%b eh=%b ti=%0d exp bin=%b gray=%b st=%b eh=%b ti=%0d",
        e.name, bin, gray, stepped, edge_hit, toggle_idx,
        e.b, e.g, e.s, e.e, e.t);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) cmp(q.pop_front());
  end

  task automatic step(
    input logic i_en, input logic i_up,
    input logic i_ld, input logic [3:0] lv,
    input logic [3:0] eb, input logic [3:0] eg,
    input logic es, input logic ee,
    input logic [1:0] et, input string nm
  );
    exp_t e;
    @(negedge clk);
    en = i_en; up = i_up; load = i_ld; load_val = lv;
    e.b = eb; e.g = eg; e.s = es; e.e = ee; e.t = et;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic chk_reset(input string nm);
    exp_t e;
    e.b = 0; e.g = 0; e.s = 0; e.e = 0; e.t = 0;
    e.name = nm;
    cmp(e);
  endtask

  localparam logic [3:0] GSEQ [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000};
  localparam logic [1:0] TSEQ [16] = '{
    0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};

  initial begin
    logic [3:0] nb;
    int nsteps7 = 0;
    #1;
    chk_reset("reset_async");
    en = 1;
    @(posedge clk); #1;
    chk_reset("reset_hold");
    @(negedge clk); rst = 0; en = 0;

    for (int i = 0; i < 16; i++) begin
      nb = 4'(i + 1);
      if (SAT && i == 15)
        step(1, 1, 0, 0, 4'd15, 4'b1000, 0, 1, 0, "sat_top");
      else
        step(1, 1, 0, 0, nb, GSEQ[nb], 1, i == 15,
             TSEQ[i], $sformatf("up_seq%0d", i));
    end
    step(0, 1, 0, 0, SAT ? 4'd15 : 4'd0,
         SAT ? 4'b1000 : 4'b0000, 0, 0,
         SAT ? 2'd0 : 2'd3, "idle_hold");

    @(negedge clk); rst = 1; en = 0;
    #1 chk_reset("reset_pulse");
    @(negedge clk); rst = 0;

    step(1, 0, 0, 0, SAT ? 4'd0 : 4'd15,
         SAT ? 4'b0000 : 4'b1000, !SAT, 1,
         SAT ? 2'd0 : 2'd3, "down_wrap");
    step(1, 1, 1, 4'b1010, 4'b1010, 4'b1111, 0, 0,
         SAT ? 2'd0 : 2'd3, "load_wins");
    step(1, 1, 0, 0, 4'b1011, 4'b1110, 1, 0, 0, "up_after_ld");
    step(1, 0, 0, 0, 4'b1010, 4'b1111, 1, 0, 0, "dir_change");
    step(0, 0, 1, 4'b1010, 4'b1010, 4'b1111, 0, 0, 0, "load_same");
    step(0, 0, 1, 4'b0101, 4'b0101, 4'b0111, 0, 0, 0, "load_5");
    step(1, 1, 0, 0, 4'b0110, 4'b0101, 1, 0, 1, "up_to_6");

    @(posedge clk); #3;
    rst = 1; en = 0;
    #1 chk_reset("reset_midcycle");
    @(posedge clk);
    @(negedge clk); rst = 0;
    step(1, 1, 0, 0, 4'd1, 4'b0001, 1, 0, 0, "resume");
    step(0, 1, 1, 4'b1111, 4'd15, 4'b1000, 0, 0, 0, "load_max");
    if (SAT) begin
      for (int i = 0; i < 3; i++)
        step(1, 1, 0, 0, 4'd15, 4'b1000, 0, 1, 0,
             $sformatf("sat_block%0d", i));
      step(0, 1, 0, 0, 4'd15, 4'b1000, 0, 0, 0, "sat_release");
    end else begin
      step(1, 1, 0, 0, 4'd0, 4'b0000, 1, 1, 3, "wrap_up");
      step(1, 1, 0, 0, 4'd1, 4'b0001, 1, 0, 0, "post_wrap1");
      step(1, 1, 0, 0, 4'd2, 4'b0011, 1, 0, 1, "post_wrap2");
      step(0, 1, 0, 0, 4'd2, 4'b0011, 0, 0, 1, "idle_end");
    end
    @(negedge clk); en = 0; load = 0;

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending exp 0", q.size());
    end

    @(negedge clk); rst7 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      prev7 = gray7;
      en7 = ($urandom_range(0, 3) != 0);
      up7 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (stepped7) begin
        nsteps7++;
        if ($countones(gray7 ^ prev7) != 1) begin
          errors++;
          $display("FAIL w7_onebit: got %b -> %b exp one bit change",
                   prev7, gray7);
        end
      end else if (gray7 !== prev7) begin
        errors++;
        $display("FAIL w7_hold: got %b exp %b", gray7, prev7);
      end
    end
    checks++;
    if (nsteps7 < 100) begin
      errors++;
      $display("FAIL w7_activity: got %0d steps exp >=100", nsteps7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
# gray_counter_param

Parametrised Gray-code counter: a generic-width, up/down, loadable successor to the fixed 4-bit Gray counter. It holds a registered binary count and a registered Gray output, so the Gray bus is glitch-free for clock-domain-crossing pointers and position encoders. It reports wrap events and which Gray bit toggled on each step. It sits wherever the design needs a CDC-safe pointer or cyclic sequence source, for example FIFO read/write pointers and rotary-position emulation.

## Interface
- WIDTH, 4: counter width in bits, 2..32.
- RST_VAL, 0: binary value loaded on reset; must be < 2**WIDTH.
- IDXW, $clog2(WIDTH): width of toggle_idx; derived, not overridden.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  step enable; one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled with en.
- load  in  1  synchronous load; overrides en.
- load_val  in  WIDTH  binary value to load.
- gray  out  WIDTH  registered Gray code of the count.
- bin  out  WIDTH  registered binary count.
- stepped  out  1  one-cycle pulse: a step occurred on the last edge.
- toggle_idx  out  IDXW  index of the gray bit that changed on the last step; valid while stepped=1, holds its value otherwise.
- edge_hit  out  1  one-cycle pulse on a boundary event (see Configuration).

## Operation
- Internal state is the binary count `cnt`. Next state is one of: load_val, cnt±1, or cnt. gray is registered as bin2gray(next), never derived combinationally from registered bin.
- Priority per edge: rst (async) > load > en > hold.
- load=1: cnt←load_val, gray←bin2gray(load_val), stepped←0, edge_hit←0, toggle_idx holds.
- en=1, up=1: cnt←cnt+1 modulo 2**WIDTH. en=1, up=0: cnt←cnt−1 modulo 2**WIDTH.
- On every step, exactly one gray bit changes. toggle_idx←index of that bit, computed from gray_old XOR gray_new; stepped←1.
- en=0, load=0: all state holds; stepped and edge_hit return to 0.
- Arithmetic is WIDTH bits, unsigned. There is no carry out beyond edge_hit.
- A direction change between cycles is legal and needs no idle cycle.

## Timing
- Reset values: bin=RST_VAL, gray=bin2gray(RST_VAL), stepped=0, edge_hit=0, toggle_idx=0. Outputs take these values immediately on rst assertion, with no clock needed.
- Release of rst is sampled synchronously: the first step can occur on the first rising edge at which rst=0 and en=1.
- Latency: every output is registered and updates on the same edge that samples en/load. There are no combinational paths from inputs to outputs.
- Wrap-around, counting up from 2**WIDTH−1 or down from 0: the step completes (modulo) and edge_hit=1 for one cycle, coincident with stepped=1.
- Load of the current value: no toggle, stepped=0.
- Reset asserted mid-step: async reset wins and no partial update is visible.

## Configuration
- GRAY_CNT_SATURATE_EN undefined (default): the counter wraps, and edge_hit pulses on each wrap step.
- GRAY_CNT_SATURATE_EN defined:
  - A step that would wrap is suppressed: cnt and gray hold, stepped=0, and toggle_idx holds.
  - edge_hit pulses for one cycle for each blocked step request, and stays high on consecutive blocked cycles.
  - load is unaffected.

## Structure
- Package gray_cnt_pkg holds:
  - bin2gray and gray2bin functions, both WIDTH-generic via a max width of 32.
  - A localparam for the maximum width.
  - The direction encoding constants DIR_DOWN=0 and DIR_UP=1.
- Sub-module gray_bit_index: a combinational priority encoder from a one-hot WIDTH-bit XOR to an IDXW-bit index. It is reused by the FIFO pointer-compare logic.

## Test plan
- WIDTH=4, RST_VAL=0, up=1, en=1 for 16 cycles:
  - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,… and returns to 0000.
  - edge_hit pulses only on the 1000→0000 step.
  - toggle_idx follows 0,1,0,2,0,1,0,3,…
- From reset, up=0, en=1 for one cycle: bin=1111, gray=1000, edge_hit=1, toggle_idx=3.
- load=1, load_val=1010 with en=1 in the same cycle: load wins, giving bin=1010, gray=1111, stepped=0. Next cycle, up=1: bin=1011, gray=1110, toggle_idx=0.
- Assert rst asynchronously mid-cycle at bin=0110: gray goes to 0000 before the next clock edge. After release, counting resumes from 0.
- Across every step in a randomised up/down/en sequence of 1000 cycles with WIDTH=7, popcount(gray_prev XOR gray) must equal 1.
- With GRAY_CNT_SATURATE_EN, WIDTH=4, hold up=1, en=1 at bin=1111 for 3 cycles: bin stays 1111, gray stays 1000, edge_hit=1 for all 3 cycles, stepped=0.
